// File: rtl/serial_pkg.sv
// Shared types and frame constants for the serial operand receiver.
// Latency: n/a (declarations only).
// Backpressure: none; the serial link has no flow control.
package serial_pkg;

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        START,
        DATA,
        SEL,
        STOP,
        DONE
    } rx_state_t;

    // Line levels of the framing bits and the select-bit value that picks register A
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic SEL_A     = 1'b0;

    localparam int DEFAULT_CLKS_PER_BIT = 16;

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1, ticks at half or full period.
// Latency: tick is combinational from the count; the count wraps on every tick.
// Backpressure: none; clear_i holds the count at zero.
module bit_timer
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic half_i,
    output logic tick_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Terminal count: mid-bit of the start bit when half_i, else one full bit later
    assign tick_o = half_i ? (cnt_q == CNT_W'(CLKS_PER_BIT/2 - 1))
                           : (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    // Wrap to zero on every sample point so error never accumulates across a frame
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear_i || tick_o) begin
            cnt_d = '0;
        end
    end

    // Count register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_operand_rx.sv
// Serial operand receiver: start/data(LSB first)/select/stop frame -> Dout + Ld_A/Ld_B strobe.
// Latency: strobe and new Dout appear the cycle after the stop-bit sample.
// Backpressure: none; a frame with a low stop bit is dropped with a Frame_Err pulse.
module serial_operand_rx
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_W       = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Rx,
    output logic [DATA_W-1:0] Dout,
    output logic              Ld_A,
    output logic              Ld_B,
    output logic              Busy,
    output logic              Frame_Err
);

    localparam int IDX_W = $clog2(DATA_W);

    rx_state_t         state_q;
    logic [IDX_W-1:0]  bit_idx_q;
    logic [DATA_W-1:0] shift_q;
    logic              sel_q;
    logic [DATA_W-1:0] dout_q;
    logic              ld_a_q;
    logic              ld_b_q;
    logic              busy_q;
    logic              ferr_q;

    logic tmr_clear;
    logic tmr_half;
    logic tick;

    // Timer free-runs only while a frame is in flight; first interval is half a bit
    assign tmr_clear = !((state_q == START) || (state_q == DATA) ||
                         (state_q == SEL)   || (state_q == STOP));
    assign tmr_half  = (state_q == START);

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk_i  (Clk),
        .rst_i  (Reset),
        .clear_i(tmr_clear),
        .half_i (tmr_half),
        .tick_o (tick)
    );

    // Frame FSM with registered strobes; Dout only changes on a good stop bit
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= WAIT_IDLE;
            bit_idx_q <= '0;
            shift_q   <= '0;
            sel_q     <= SEL_A;
            dout_q    <= '0;
            ld_a_q    <= 1'b0;
            ld_b_q    <= 1'b0;
            busy_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            ld_a_q <= 1'b0;
            ld_b_q <= 1'b0;
            ferr_q <= 1'b0;
            unique case (state_q)
                // Never lock onto a low line seen after reset or a bad frame
                WAIT_IDLE: begin
                    if (Rx) begin
                        state_q <= IDLE;
                    end
                end
                IDLE: begin
                    if (Rx == START_BIT) begin
                        state_q <= START;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        if (Rx != START_BIT) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q   <= DATA;
                            bit_idx_q <= '0;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift_q <= {Rx, shift_q[DATA_W-1:1]};
                        if (bit_idx_q == IDX_W'(DATA_W - 1)) begin
                            state_q <= SEL;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end
                end
                SEL: begin
                    if (tick) begin
                        sel_q   <= Rx;
                        state_q <= STOP;
                    end
                end
                STOP: begin
                    if (tick) begin
                        busy_q <= 1'b0;
                        if (Rx == STOP_BIT) begin
                            state_q <= DONE;
                            dout_q  <= shift_q;
                            ld_a_q  <= (sel_q == SEL_A);
                            ld_b_q  <= (sel_q != SEL_A);
                        end else begin
                            state_q <= WAIT_IDLE;
                            ferr_q  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= WAIT_IDLE;
                end
            endcase
        end
    end

    assign Dout      = dout_q;
    assign Ld_A      = ld_a_q;
    assign Ld_B      = ld_b_q;
    assign Busy      = busy_q;
    assign Frame_Err = ferr_q;

endmodule

// File: tb/tb_serial_operand_rx.sv
// Bench for serial_operand_rx: framed stimulus against an event-level reference model.
// Latency: expects strobes at stop sample + 1 cycle.
// Backpressure: n/a.
module tb_serial_operand_rx;

    localparam int C        = 16;
    localparam int W        = 8;
    localparam int STOP_OFS = C/2 + (W + 2)*C;   // stop-sample edge relative to cycle 0
    localparam int K_A      = 0;
    localparam int K_B      = 1;
    localparam int K_ERR    = 2;

    logic         Clk   = 1'b0;
    logic         Reset = 1'b1;
    logic         Rx    = 1'b1;
    logic [W-1:0] Dout;
    logic         Ld_A;
    logic         Ld_B;
    logic         Busy;
    logic         Frame_Err;

    typedef struct {
        int kind;
        int ev_edge;
        int dout;
    } ev_t;

    ev_t obs_q[$];
    ev_t exp_q[$];
    int  obs_rd      = 0;
    int  edge_n      = 0;
    int  busy_cycles = 0;
    int  model_dout  = 0;
    int  n_vec       = 0;
    int  n_err       = 0;

    serial_operand_rx #(
        .CLKS_PER_BIT(C),
        .DATA_W      (W)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Rx       (Rx),
        .Dout     (Dout),
        .Ld_A     (Ld_A),
        .Ld_B     (Ld_B),
        .Busy     (Busy),
        .Frame_Err(Frame_Err)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) edge_n = edge_n + 1;

    // Record every strobe, tagged with the last rising edge, away from the active edge
    always @(negedge Clk) begin
        if (Busy === 1'b1) busy_cycles = busy_cycles + 1;
        if (Ld_A === 1'b1)      obs_q.push_back('{K_A,   edge_n, int'(Dout)});
        if (Ld_B === 1'b1)      obs_q.push_back('{K_B,   edge_n, int'(Dout)});
        if (Frame_Err === 1'b1) obs_q.push_back('{K_ERR, edge_n, int'(Dout)});
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        Rx = 1'b1;
        tick(n);
    endtask

    // Sends one whole frame starting now; cycle 0 is the next rising edge
    task automatic send_frame(input logic [W-1:0] data, input logic sel, input logic stop,
                              output int e0);
        logic [W+2:0] bits;
        bits = {stop, sel, data, 1'b0};
        e0   = edge_n + 1;
        for (int b = 0; b < W + 3; b++) begin
            Rx = bits[b];
            for (int k = 0; k < C; k++) begin
                @(posedge Clk);
                #1;
                if (b == 0 && k == 0) check_val("busy_rise", {31'd0, Busy}, 32'd1);
            end
        end
        check_val("busy_fall", {31'd0, Busy}, 32'd0);
        if (stop) begin
            model_dout = int'(data);
            exp_q.push_back('{(sel ? K_B : K_A), e0 + STOP_OFS, int'(data)});
        end else begin
            exp_q.push_back('{K_ERR, e0 + STOP_OFS, model_dout});
        end
    endtask

    task automatic compare_events(input string ph);
        int n_obs;
        int n;
        n_obs = obs_q.size() - obs_rd;
        n     = (n_obs < exp_q.size()) ? n_obs : exp_q.size();
        check_val({ph, "_events"}, n_obs, exp_q.size());
        for (int i = 0; i < n; i++) begin
            check_val({ph, "_kind"}, obs_q[obs_rd + i].kind,    exp_q[i].kind);
            check_val({ph, "_edge"}, obs_q[obs_rd + i].ev_edge, exp_q[i].ev_edge);
            check_val({ph, "_dout"}, obs_q[obs_rd + i].dout,    exp_q[i].dout);
        end
        obs_rd = obs_q.size();
        exp_q.delete();
        check_val({ph, "_dout_now"}, Dout, model_dout);
    endtask

    task automatic check_all_clear(input string ph);
        check_val({ph, "_dout"}, Dout, 32'd0);
        check_val({ph, "_ld_a"}, Ld_A, 32'd0);
        check_val({ph, "_ld_b"}, Ld_B, 32'd0);
        check_val({ph, "_busy"}, Busy, 32'd0);
        check_val({ph, "_ferr"}, Frame_Err, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int e0;
        int e1;
        int b0;
        logic [W-1:0] d;
        logic         s;
        logic         st;
        logic         prev_bad;

        // Reset and idle line
        Reset = 1'b1;
        Rx    = 1'b1;
        tick(2);
        Reset = 1'b0;
        check_all_clear("reset");
        b0 = busy_cycles;
        idle(200);
        check_val("idle_busy_cycles", busy_cycles - b0, 0);
        compare_events("idle");

        // Load A with cycle-accurate strobe position
        send_frame(8'hA5, 1'b0, 1'b1, e0);
        idle(5);
        if (obs_q.size() > obs_rd)
            check_val("ldA_cycle", obs_q[obs_rd].ev_edge - e0 + 1, 169);
        compare_events("loadA");

        // Load B then A with no gap between frames
        send_frame(8'h3C, 1'b1, 1'b1, e0);
        send_frame(8'hFF, 1'b0, 1'b1, e1);
        idle(5);
        if (obs_q.size() > obs_rd + 1)
            check_val("b2b_gap", obs_q[obs_rd + 1].ev_edge - obs_q[obs_rd].ev_edge, (W + 3)*C);
        compare_events("b2b");

        // Start-bit glitch: three low cycles, then high
        b0 = busy_cycles;
        Rx = 1'b0;
        tick(3);
        Rx = 1'b1;
        tick(2*C);
        check_val("glitch_busy_cycles", busy_cycles - b0, C/2);
        check_val("glitch_busy_now", {31'd0, Busy}, 32'd0);
        compare_events("glitch");

        // Framing error, then line held low: no new frame until it goes high
        send_frame(8'h12, 1'b1, 1'b0, e0);
        b0 = busy_cycles;
        Rx = 1'b0;
        tick(300);
        check_val("ferr_low_busy_cycles", busy_cycles - b0, 0);
        compare_events("ferr");
        idle(3);
        send_frame(8'h5A, 1'b1, 1'b1, e0);
        idle(5);
        compare_events("after_ferr");

        // Reset during data bit 4 with the line low
        Rx = 1'b0;
        tick(5*C + 4);
        Reset = 1'b1;
        tick(1);
        Reset = 1'b0;
        model_dout = 0;
        check_all_clear("midreset");
        b0 = busy_cycles;
        tick(200);
        check_val("midreset_busy_cycles", busy_cycles - b0, 0);
        compare_events("midreset");
        idle(2);
        send_frame(8'h81, 1'b1, 1'b1, e0);
        idle(5);
        compare_events("after_reset");

        // Randomized frames with random gaps and occasional bad stop bits
        prev_bad = 1'b0;
        for (int f = 0; f < 10; f++) begin
            d  = W'($urandom);
            s  = 1'($urandom_range(0, 1));
            st = ($urandom_range(0, 3) != 0);
            if (prev_bad) idle(1 + $urandom_range(0, 5));
            else          idle($urandom_range(0, 3));
            send_frame(d, s, st, e0);
            prev_bad = !st;
        end
        idle(5);
        compare_events("rand");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_operand_rx.md
# serial_operand_rx

Receives framed serial operand bytes on a single wire and converts them into the parallel `Din` value plus a one-cycle `Ld_A`/`Ld_B` strobe for the register unit. This replaces the switch-and-pushbutton operand entry path. It sits between the `Rx` input synchronizer and the register unit's parallel-load port. It is the receiving end of the team's serial operand link, and mirrors how the processor shifts register contents out serially.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Must be even and ≥ 4.
- `DATA_W`, default 8: data bits per frame. Matches register width.
- `Clk` input, 1 bit: system clock. All logic is on the rising edge.
- `Reset` input, 1 bit: one clock; reset is synchronous and active-high.
- `Rx` input, 1 bit: serial line, already synchronized. Idles high.
- `Dout` output, `DATA_W` bits: last good received byte. Drives the register unit's `D`.
- `Ld_A` output, 1 bit: one-cycle strobe to load `Dout` into A.
- `Ld_B` output, 1 bit: one-cycle strobe to load `Dout` into B.
- `Busy` output, 1 bit: high from start-bit detection through the end of the stop bit.
- `Frame_Err` output, 1 bit: one-cycle strobe when the stop bit is sampled low.

## Operation
- Frame format, in order:
  - start bit (0)
  - `DATA_W` data bits, LSB first
  - select bit (0 selects A, 1 selects B)
  - stop bit (1)
- States:
  - `WAIT_IDLE` to `IDLE`: when `Rx`=1.
  - `IDLE` to `START`: when `Rx`=0.
  - `START`: sample at mid-bit. If `Rx`=1 (glitch), go to `IDLE`. Otherwise go to `DATA`.
  - `DATA`: shift in `DATA_W` bits, then go to `SEL`.
  - `SEL`: latch the select bit, then go to `STOP`.
  - `STOP`: if `Rx`=1, go to `DONE`. Otherwise go to `WAIT_IDLE` with a `Frame_Err` pulse.
  - `DONE` to `IDLE`: unconditional, in one cycle.
- Data shifts into a private shift register. `Dout` updates only on entry to `DONE`, so a bad frame leaves `Dout` unchanged.
- `Ld_A`/`Ld_B` are asserted only in `DONE`, exactly one of them, chosen by the latched select bit. They are never asserted together.
- Reset values:
  - `Dout`=0
  - `Ld_A`=`Ld_B`=`Frame_Err`=`Busy`=0
  - state = `WAIT_IDLE`
- Reset asserted mid-frame abandons the frame. The block then requires `Rx` high before it accepts a new start, which prevents locking onto a mid-frame 0.
- `Busy` is 1 in `START`, `DATA`, `SEL` and `STOP`. It is 0 elsewhere.

## Timing
- Cycle 0 is the first cycle `IDLE` samples `Rx`=0.
- Sample points, with C = `CLKS_PER_BIT`:
  - start verified at cycle C/2
  - data bit i sampled at C/2 + (i+1)·C
  - select bit sampled at C/2 + (`DATA_W`+1)·C
  - stop bit sampled at C/2 + (`DATA_W`+2)·C
- The `Ld_x` strobe and the new `Dout` appear in the cycle after the stop sample. With defaults that is cycle 169.
- `Frame_Err` is asserted in the cycle after a bad stop sample.
- Back-to-back frames:
  - A start bit may begin immediately after the stop bit.
  - `IDLE` is re-entered at stop sample + 2. This is within the second half of the stop bit, so no start edge is missed.
- `Busy` rises the cycle after cycle 0. It falls the cycle after the stop sample.
- The bit counter wraps to 0 at each sample. No drift accumulates across a frame.

## Structure
- Package `serial_pkg` holds:
  - the state enum `rx_state_t` (`WAIT_IDLE`, `IDLE`, `START`, `DATA`, `SEL`, `STOP`, `DONE`)
  - the frame constants `START_BIT`=0, `STOP_BIT`=1 and `SEL_A`=0
  - the default `CLKS_PER_BIT`
- One sub-module, `bit_timer`:
  - counts 0..`CLKS_PER_BIT`−1
  - produces a `tick` on its half-period or full-period terminal count, per a `half` input
  - uses a synchronous `clear`
- The top level holds the FSM, the bit index counter, the shift register and the output registers.

## Test plan
- **Reset and idle:** hold `Reset` for 2 cycles with `Rx`=1. All outputs must be 0. With `Rx` held 1 for 200 cycles, no strobe may occur.
- **Load A:** send data 0xA5 with select 0 and a good stop. `Dout`=0xA5 with a single `Ld_A` pulse at cycle 169. `Ld_B` must stay 0.
- **Load B, back to back:** send 0x3C with select 1, then immediately 0xFF with select 0. Expect `Ld_B` with `Dout`=0x3C, then `Ld_A` with `Dout`=0xFF, exactly 176 cycles apart.
- **Glitch rejection:** drive `Rx`=0 for 3 cycles, then 1. There must be no `Busy` after cycle C/2, no strobe, and a return to `IDLE`.
- **Framing error:** send 0x12 with stop bit 0. Expect a `Frame_Err` pulse, `Dout` still holding its previous value, and no `Ld_x`. With `Rx` held low afterwards, there must be no new frame until `Rx` returns high.
- **Reset mid-frame:** assert `Reset` during data bit 4 with `Rx`=0. All outputs clear, and there must be no strobe. The next good frame (0x81, B) must be received correctly.
